bip_control: RTL and testbench

Control unit for the BIP accumulator processor: holds the program counter and instruction register, fetches 16-bit instructions from synchronous program memory, decodes them, and drives the select, write and ALU-operation strobes of the accumulator datapath and the data-memory strobes. Sits directly upstream of the datapath. Runs a three-state FETCH/LOAD/EXEC sequence until it executes HLT.

---
 rtl/bip_control.sv | 146 ++++++++++++++
 tb/tb_bip_control.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// BIP accumulator-processor control unit: PC/IR, FETCH/LOAD/EXEC/HALT sequencing, strobe decode.
// Optional BIP_CYCLE_COUNTER_EN adds a saturating CYCLE_COUNT output.
module bip_control #(
  parameter int PC_WIDTH    = 11,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ENABLE,
  input  logic [INSTR_WIDTH-1:0] PM_DATA,
  output logic [PC_WIDTH-1:0]    PM_ADDR,
  output logic [PC_WIDTH-1:0]    OPERAND,
  output logic [1:0]             SEL_A,
  output logic                   SEL_B,
  output logic                   OP,
  output logic                   WR_ACC,
  output logic                   RD_RAM,
  output logic                   WR_RAM,
  output logic                   HALTED
`ifdef BIP_CYCLE_COUNTER_EN
  ,
  output logic [15:0]            CYCLE_COUNT
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_LOAD, S_EXEC, S_HALT} state_t;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SRC_DM  = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_ALU = 2'b10;

  state_t                 state, state_nx;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] ir;
  logic [4:0]             opcode;
  logic                   exec_go;

  assign opcode  = ir[INSTR_WIDTH-1 -: 5];
  assign exec_go = ENABLE && (state == S_EXEC);

  assign PM_ADDR = pc;
  assign OPERAND = ir[PC_WIDTH-1:0];
  assign HALTED  = (state == S_HALT);

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_FETCH;
    else          state <= state_nx;
  end

  // Next-state logic; ENABLE low holds whatever state we are in
  always_comb begin
    state_nx = state;
    if (ENABLE) begin
      case (state)
        S_FETCH: state_nx = S_LOAD;
        S_LOAD:  state_nx = S_EXEC;
        S_EXEC:  state_nx = (opcode == OPC_HLT) ? S_HALT : S_FETCH;
        S_HALT:  state_nx = S_HALT;
        default: state_nx = S_FETCH;
      endcase
    end
  end

  // PC advances only on a non-HLT EXEC; wraps naturally at the top of program memory
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                           pc <= '0;
    else if (exec_go && opcode != OPC_HLT)  pc <= pc + 1'b1;
  end

  // PM_DATA holds the word addressed during FETCH
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                         ir <= '0;
    else if (ENABLE && state == S_LOAD)   ir <= PM_DATA;
  end

  // Output decode: strobes live only in an enabled EXEC cycle
  always_comb begin
    SEL_A  = SRC_DM;
    SEL_B  = 1'b0;
    OP     = 1'b0;
    WR_ACC = 1'b0;
    RD_RAM = 1'b0;
    WR_RAM = 1'b0;
    if (exec_go) begin
      case (opcode)
        OPC_STO: WR_RAM = 1'b1;
        OPC_LD: begin
          RD_RAM = 1'b1;
          SEL_A  = SRC_DM;
          WR_ACC = 1'b1;
        end
        OPC_LDI: begin
          SEL_A  = SRC_IMM;
          WR_ACC = 1'b1;
        end
        OPC_ADD: begin
          RD_RAM = 1'b1;
          SEL_B  = 1'b1;
          SEL_A  = SRC_ALU;
          WR_ACC = 1'b1;
        end
        OPC_ADDI: begin
          SEL_A  = SRC_ALU;
          WR_ACC = 1'b1;
        end
        OPC_SUB: begin
          RD_RAM = 1'b1;
          SEL_B  = 1'b1;
          OP     = 1'b1;
          SEL_A  = SRC_ALU;
          WR_ACC = 1'b1;
        end
        OPC_SUBI: begin
          OP     = 1'b1;
          SEL_A  = SRC_ALU;
          WR_ACC = 1'b1;
        end
        default: ;  // HLT and 01000..11111 issue nothing
      endcase
    end
  end

`ifdef BIP_CYCLE_COUNTER_EN
  logic [15:0] cycle_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      cycle_cnt <= '0;
    else if (ENABLE && state != S_HALT && cycle_cnt != 16'hFFFF)
      cycle_cnt <= cycle_cnt + 16'd1;
  end

  assign CYCLE_COUNT = cycle_cnt;
`endif

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: per-opcode vector table plus multi-cycle sequences.
module tb_bip_control;

  logic        CLK;
  logic        RESET_N;
  logic        ENABLE;
  logic [15:0] PM_DATA;
  logic [10:0] PM_ADDR;
  logic [10:0] OPERAND;
  logic [1:0]  SEL_A;
  logic        SEL_B;
  logic        OP;
  logic        WR_ACC;
  logic        RD_RAM;
  logic        WR_RAM;
  logic        HALTED;
`ifdef BIP_CYCLE_COUNTER_EN
  logic [15:0] CYCLE_COUNT;
`endif

  bip_control #(.PC_WIDTH(11), .INSTR_WIDTH(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .PM_DATA(PM_DATA),
    .PM_ADDR(PM_ADDR), .OPERAND(OPERAND), .SEL_A(SEL_A), .SEL_B(SEL_B),
    .OP(OP), .WR_ACC(WR_ACC), .RD_RAM(RD_RAM), .WR_RAM(WR_RAM),
    .HALTED(HALTED)
`ifdef BIP_CYCLE_COUNTER_EN
    , .CYCLE_COUNT(CYCLE_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous program memory
  logic [15:0] mem [0:2047];
  always_ff @(posedge CLK) PM_DATA <= mem[PM_ADDR];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {SEL_A, SEL_B, OP, WR_ACC, RD_RAM, WR_RAM}
  function automatic logic [6:0] strb();
    return {SEL_A, SEL_B, OP, WR_ACC, RD_RAM, WR_RAM};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) mem[i] = w;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    ENABLE  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [6:0]  strb;
    logic [10:0] next_pc;
    logic        halted;
  } vec_t;

  vec_t vecs [10];

  initial begin
    RESET_N = 1'b0;
    ENABLE  = 1'b1;
    fill(16'h0000);

    vecs[0] = '{"hlt",   16'h0000, 7'b00_0_0_0_0_0, 11'd0, 1'b1};
    vecs[1] = '{"sto",   16'h0807, 7'b00_0_0_0_0_1, 11'd1, 1'b0};
    vecs[2] = '{"ld",    16'h1012, 7'b00_0_0_1_1_0, 11'd1, 1'b0};
    vecs[3] = '{"ldi",   16'h1805, 7'b01_0_0_1_0_0, 11'd1, 1'b0};
    vecs[4] = '{"add",   16'h27FF, 7'b10_1_0_1_1_0, 11'd1, 1'b0};
    vecs[5] = '{"addi",  16'h2803, 7'b10_0_0_1_0_0, 11'd1, 1'b0};
    vecs[6] = '{"sub",   16'h3004, 7'b10_1_1_1_1_0, 11'd1, 1'b0};
    vecs[7] = '{"subi",  16'h3955, 7'b10_0_1_1_0_0, 11'd1, 1'b0};
    vecs[8] = '{"nop40", 16'h4000, 7'b00_0_0_0_0_0, 11'd1, 1'b0};
    vecs[9] = '{"nopF8", 16'hF800, 7'b00_0_0_0_0_0, 11'd1, 1'b0};

    // One instruction per vector, each from a fresh reset
    for (int v = 0; v < 10; v++) begin
      fill(16'h0000);
      mem[0] = vecs[v].instr;
      do_reset();
      chk({vecs[v].name, ".rst_pc"}, PM_ADDR, 11'd0);
      chk({vecs[v].name, ".rst_opnd"}, OPERAND, 11'd0);
      chk({vecs[v].name, ".fetch_strb"}, strb(), 7'd0);
      chk({vecs[v].name, ".rst_halted"}, HALTED, 1'b0);
      step();
      chk({vecs[v].name, ".load_strb"}, strb(), 7'd0);
      step();
      chk({vecs[v].name, ".exec_strb"}, strb(), vecs[v].strb);
      chk({vecs[v].name, ".exec_opnd"}, OPERAND, {21'd0, vecs[v].instr[10:0]});
      step();
      chk({vecs[v].name, ".next_pc"}, PM_ADDR, vecs[v].next_pc);
      chk({vecs[v].name, ".halted"}, HALTED, vecs[v].halted);
      chk({vecs[v].name, ".post_strb"}, strb(), 7'd0);
    end

    // LDI 5, ADDI 3, HLT: cycle-accurate trace
    fill(16'h0000);
    mem[0] = 16'h1805;
    mem[1] = 16'h2803;
    mem[2] = 16'h0000;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("prog.pc.c%0d", c), PM_ADDR, (c <= 3) ? 11'd0 : (c <= 6) ? 11'd1 : 11'd2);
      chk($sformatf("prog.wr_acc.c%0d", c), WR_ACC, (c == 3 || c == 6) ? 1'b1 : 1'b0);
      chk($sformatf("prog.sel_a.c%0d", c), SEL_A, (c == 3) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00);
      chk($sformatf("prog.halted.c%0d", c), HALTED, (c >= 10) ? 1'b1 : 1'b0);
`ifdef BIP_CYCLE_COUNTER_EN
      chk($sformatf("prog.cnt.c%0d", c), CYCLE_COUNT, (c <= 10) ? c - 1 : 9);
`endif
      step();
    end
    ENABLE = 1'b0;
    repeat (2) step();
    ENABLE = 1'b1;
    repeat (3) step();
    chk("halt.absorb", HALTED, 1'b1);
    chk("halt.pc", PM_ADDR, 11'd2);
    chk("halt.strb", strb(), 7'd0);

    // Stall in LOAD, stall in EXEC, undefined opcode, reset mid-EXEC
    fill(16'h0000);
    mem[0] = 16'h3004;
    mem[1] = 16'hF800;
    mem[2] = 16'h1805;
    do_reset();
    step();               // LOAD
    ENABLE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall.pc.%0d", k), PM_ADDR, 11'd0);
      chk($sformatf("stall.strb.%0d", k), strb(), 7'd0);
    end
    ENABLE = 1'b1;
    #1;
    chk("stall.still_load", strb(), 7'd0);
    step();               // EXEC of SUB 4
    chk("sub.strb", strb(), 7'b10_1_1_1_1_0);
    chk("sub.opnd", OPERAND, 11'd4);
    ENABLE = 1'b0;
    #1;
    chk("exec_stall.strb", strb(), 7'd0);
    step();
    chk("exec_stall.pc", PM_ADDR, 11'd0);
    ENABLE = 1'b1;
    #1;
    chk("exec_reissue.strb", strb(), 7'b10_1_1_1_1_0);
    step();
    chk("sub.next_pc", PM_ADDR, 11'd1);
    step();
    step();               // EXEC of 0xF800
    chk("undef.strb", strb(), 7'd0);
    step();
    chk("undef.next_pc", PM_ADDR, 11'd2);
    step();
    step();               // EXEC of LDI 5
    chk("after_undef.strb", strb(), 7'b01_0_0_1_0_0);
    chk("after_undef.opnd", OPERAND, 11'd5);
    RESET_N = 1'b0;
    #1;
    chk("midexec_rst.strb", strb(), 7'd0);
    chk("midexec_rst.pc", PM_ADDR, 11'd0);
    chk("midexec_rst.halted", HALTED, 1'b0);
    step();
    chk("midexec_rst.held_pc", PM_ADDR, 11'd0);
    RESET_N = 1'b1;

    // Walk PC through all of memory to see the wrap, then STO at 0
    fill(16'h4000);
    mem[0] = 16'h0809;
    do_reset();
    repeat (2047 * 3) step();
    chk("wrap.pc_top", PM_ADDR, 11'd2047);
    step();
    step();
    chk("wrap.exec_strb", strb(), 7'd0);
    step();
    chk("wrap.pc_zero", PM_ADDR, 11'd0);
    step();
    step();
    chk("wrap.sto_strb", strb(), 7'b00_0_0_0_0_1);
    chk("wrap.sto_opnd", OPERAND, 11'd9);
    RESET_N = 1'b0;
    #1;
    chk("wrap_rst.strb", strb(), 7'd0);
    chk("wrap_rst.opnd", OPERAND, 11'd0);
    chk("wrap_rst.halted", HALTED, 1'b0);
    step();
    RESET_N = 1'b1;
    chk("wrap_rst.pc", PM_ADDR, 11'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
